alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue-and-writeback controller wrapped around the CPU's 24-bit combinational ALU. It accepts one instruction at a time over a valid/ready handshake and holds an 8×24-bit register file. For each instruction it reads the operands, drives the ALU's `a`/`b`/`select` inputs from registers, captures the ALU result `c`, and writes the result back. It sits directly upstream of the ALU (it feeds the ALU) and directly downstream of it (it consumes `c`), between instruction decode and the ALU.

## Interface
- `DATA_W`, 24, datapath width; must match the ALU.
- `NREG`, 8, register count; `REG_AW = $clog2(NREG)` = 3.
- `OP_W`, 3, ALU select width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  block can accept; combinational, equals state==IDLE.
- `instr_op`  in  OP_W  ALU select for this instruction.
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  REG_AW each  destination and source registers.
- `instr_imm_en`  in  1  1: operand b comes from `instr_imm` instead of rs2.
- `instr_imm`  in  DATA_W  immediate operand.
- `alu_a`, `alu_b`  out  DATA_W  registered operands to the ALU.
- `alu_sel`  out  OP_W  registered ALU select.
- `alu_c`  in  DATA_W  ALU result; combinational from `alu_a`/`alu_b`/`alu_sel`.
- `done_valid`  out  1  one-cycle pulse per retired instruction.
- `done_rd`  out  REG_AW  destination of the retired instruction.
- `done_data`  out  DATA_W  value written.
- `dbg_addr`  in  REG_AW  debug read address.
- `dbg_data`  out  DATA_W  combinational read of `regfile[dbg_addr]`.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE→EXEC on `instr_valid & instr_ready`.
  - EXEC→WB unconditionally.
  - WB→IDLE unconditionally.
- Accept edge (IDLE):
  - `alu_a <= R[rs1]`.
  - `alu_b <= imm_en ? imm : R[rs2]`.
  - `alu_sel <= op`.
  - rd is latched internally.
- EXEC edge: `result_q <= alu_c`.
- WB edge:
  - `R[rd] <= result_q`, unless rd==0.
  - `done_valid <= 1`, `done_rd <= rd`, `done_data <= result_q`.
- `done_valid` is cleared on the following edge.
- r0 reads as 0 and ignores writes. `done_valid` still pulses for rd==0, with `done_data` = the computed result.
- `instr_*` inputs are ignored outside IDLE. The issuer must hold its fields stable only in the accept cycle.
- `alu_a`/`alu_b`/`alu_sel` hold their last values in WB and IDLE. They change only at accept edges.
- Width: all values are DATA_W bits. The block does no extension or truncation; the ALU wraps.

## Timing
- Reset (async assert, sync-safe release):
  - state=IDLE, so `instr_ready`=1.
  - All R[i]=0.
  - `alu_a`=`alu_b`=0, `alu_sel`=0.
  - `result_q`=0.
  - `done_valid`=0, `done_rd`=0, `done_data`=0.
- Latency: accept at edge E0 → `done_valid` high E2..E3 → `R[rd]` visible from E2.
- Throughput: one instruction per 3 cycles. `instr_ready` is low from E0 to E2 and high again after E2.
- Back-to-back dependency: the next instruction accepted at E3 reads the updated `R[rd]`. No forwarding is needed; a RAW hazard cannot occur.
- `dbg_data` shows the old value during the WB cycle and the new value after the WB edge.
- `rst` asserted in EXEC or WB aborts the instruction. There is no register write and no `done_valid`.
- `instr_valid` held high continuously is accepted once per IDLE visit.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`, `REG_AW`, `OP_W` constants.
  - State enum `issue_state_t {IDLE, EXEC, WB}`.
- Sub-module `cpu_regfile`: NREG×DATA_W, r0 hardwired to zero, two read ports plus debug read port, one synchronous write port, async reset clear.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Bench ALU stub:
  - sel 0: c = a + b.
  - sel 1: c = a − b.
  - others: c = a ^ b.
- Reset then idle:
  - all outputs 0, `instr_ready`=1.
  - `dbg_data`=0 for addr 0..7.
- Immediate add:
  - issue op0, rd=1, rs1=0, imm_en=1, imm=4 → `done_valid` pulse 2 edges after accept, with `done_rd`=1, `done_data`=4.
  - then issue op0, rd=2, rs1=1, imm=2 → `done_data`=6.
- Register-register subtract with wrap: with R1=2, R2=6, issue op1, rd=3, rs1=1, rs2=2 → `done_data`=0xFFFFFC, R3=0xFFFFFC.
- Back-to-back RAW with `instr_valid` held high: R1=4, issue op0 rd=1 rs1=1 imm=1 three times → `done_data` 5, 6, 7, with accepts exactly 3 cycles apart.
- rd=0 write: op0, rd=0, imm=9 → `done_valid`=1 with `done_data`=9; `dbg_data`(0) stays 0.
- Reset during EXEC of op0 rd=4 imm=7 → no `done_valid`, R4=0, `instr_ready`=1 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and issue-FSM state encoding for the ALU issue/writeback path.
package cpu_pkg;
  localparam int DATA_W = 24;
  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } issue_state_t;
endpackage

// File: rtl/cpu_regfile.sv
// NREG x DATA_W register file: two operand reads plus a debug read, all combinational; one synchronous write.
// r0 is hardwired to zero. Writes to r0 are dropped. Async reset clears every entry.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1 == '0)   ? '0 : mem[raddr1];
  assign rdata2   = (raddr2 == '0)   ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction to an external combinational ALU and writes the result back: accept, EXEC, WB (done 2 edges after accept).
// Backpressure: instr_ready is high only in IDLE, so at most one instruction is accepted every 3 cycles.
module alu_issue_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_c,
  output logic              done_valid,
  output logic [REG_AW-1:0] done_rd,
  output logic [DATA_W-1:0] done_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  issue_state_t      state, state_n;
  logic              accept;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  cpu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (instr_rs1),
    .rdata1   (rs1_data),
    .raddr2   (instr_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (state == WB),
    .waddr    (rd_q),
    .wdata    (result_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        accept      = instr_valid;
        if (instr_valid) state_n = EXEC;
      end
      EXEC:    state_n = WB;
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands are registered at accept and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      done_valid <= 1'b0;
      done_rd    <= '0;
      done_data  <= '0;
    end else begin
      if (accept) begin
        alu_a   <= rs1_data;
        alu_b   <= instr_imm_en ? instr_imm : rs2_data;
        alu_sel <= instr_op;
        rd_q    <= instr_rd;
      end
      if (state == EXEC) result_q <= alu_c;
      done_valid <= (state == WB);
      if (state == WB) begin
        done_rd   <= rd_q;
        done_data <= result_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU stub (0: add, 1: sub, else xor).
module tb_alu_issue_ctrl;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op = '0;
  logic [REG_AW-1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic              instr_imm_en = 1'b0;
  logic [DATA_W-1:0] instr_imm = '0;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic [OP_W-1:0]   alu_sel;
  logic              done_valid;
  logic [REG_AW-1:0] done_rd;
  logic [DATA_W-1:0] done_data;
  logic [REG_AW-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      3'd0:    alu_c = alu_a + alu_b;
      3'd1:    alu_c = alu_a - alu_b;
      default: alu_c = alu_a ^ alu_b;
    endcase
  end

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_c        (alu_c),
    .done_valid   (done_valid),
    .done_rd      (done_rd),
    .done_data    (done_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [23:0] imm);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_imm_en = imm_en; instr_imm = imm;
  endtask

  // Called from a negedge-aligned point; drives one accept cycle.
  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic imm_en, input logic [23:0] imm);
    @(negedge clk);
    check({tag, "_ready"}, 32'(instr_ready), 32'd1);
    set_fields(op, rd, rs1, rs2, imm_en, imm);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Counts negedges until done_valid; sample 2 falls in the WB cycle.
  task automatic wait_done(output int n, output logic [23:0] wb_dbg);
    n = 0;
    wb_dbg = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) wb_dbg = dbg_data;
      if (done_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                     input logic [2:0] rs2, input logic imm_en, input logic [23:0] imm,
                     input logic [23:0] exp_data);
    int n;
    logic [23:0] wb_dbg;
    issue(tag, op, rd, rs1, rs2, imm_en, imm);
    wait_done(n, wb_dbg);
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_rd"}, 32'(done_rd), 32'(rd));
    check({tag, "_data"}, 32'(done_data), 32'(exp_data));
  endtask

  initial begin
    int n;
    logic [23:0] wb_dbg;
    logic [23:0] exp_seq [3];

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_done_rd", 32'(done_rd), 32'd0);
    check("rst_done_data", 32'(done_data), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 check($sformatf("rst_dbg%0d", i), 32'(dbg_data), 32'd0);
    end

    // Immediate adds, then operand hold in IDLE
    run("addi1", 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 24'd4, 24'd4);
    run("addi2", 3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 24'd2, 24'd6);
    @(negedge clk);
    check("hold_alu_a", 32'(alu_a), 32'd4);
    check("hold_alu_b", 32'(alu_b), 32'd2);
    check("done_pulse_clear", 32'(done_valid), 32'd0);

    // R1=2, R2=6; subtract wraps; R3 old during WB, new afterwards
    run("setr1", 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 24'd2, 24'd2);
    dbg_addr = 3'd3;
    issue("sub", 3'd1, 3'd3, 3'd1, 3'd2, 1'b0, 24'hABCDEF);
    wait_done(n, wb_dbg);
    check("sub_lat", 32'(n), 32'd3);
    check("sub_data", 32'(done_data), 32'hFFFFFC);
    check("sub_wb_old", 32'(wb_dbg), 32'd0);
    check("sub_r3", 32'(dbg_data), 32'hFFFFFC);

    run("xor", 3'd2, 3'd5, 3'd3, 3'd0, 1'b1, 24'hFFFFFF, 24'h000003);

    // Back-to-back RAW with instr_valid held high
    run("setr1b", 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 24'd4, 24'd4);
    exp_seq[0] = 24'd5; exp_seq[1] = 24'd6; exp_seq[2] = 24'd7;
    @(negedge clk);
    set_fields(3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 24'd1);
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(n, wb_dbg);
      check($sformatf("raw%0d_spacing", k), 32'(n), 32'd3);
      check($sformatf("raw%0d_data", k), 32'(done_data), 32'(exp_seq[k]));
    end
    instr_valid = 1'b0;
    dbg_addr = 3'd1;
    #1 check("raw_r1", 32'(dbg_data), 32'd7);

    // Write to r0 still retires but is discarded
    run("r0", 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 24'd9, 24'd9);
    dbg_addr = 3'd0;
    #1 check("r0_dbg", 32'(dbg_data), 32'd0);

    // Reset during EXEC aborts the instruction
    issue("abort", 3'd0, 3'd4, 3'd0, 3'd0, 1'b1, 24'd7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_done", 32'(done_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_valid) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    dbg_addr = 3'd4;
    #1 check("abort_r4", 32'(dbg_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
